// File: rtl/address_encoder_pkg.sv
// Shared types and helpers for the round-robin address encoder.
// Holds the FSM state encoding, default sizes and a one-hot helper.
package address_encoder_pkg;

    localparam int N_REQ_DEF = 8;
    localparam int ADR_W_DEF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // One-hot of an index, sized for the largest supported request count.
    function automatic logic [63:0] onehot(input logic [5:0] adr);
        onehot = 64'd1 << adr;
    endfunction

endpackage

// File: rtl/address_encoder_rr_pick.sv
// Masked priority encoder: first set bit at or above ptr, else wraps to bit 0.
// Purely combinational; any flags a non-empty input vector.
module rr_pick #(
    parameter int N_REQ = 8,
    parameter int ADR_W = 3
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [ADR_W-1:0] ptr,
    output logic [ADR_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] up_mask;
    logic [N_REQ-1:0] masked;

    function automatic logic [ADR_W-1:0] lowest(input logic [N_REQ-1:0] v);
        lowest = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) lowest = ADR_W'(i);
        end
    endfunction

    assign up_mask = {N_REQ{1'b1}} << ptr;
    assign masked  = vec & up_mask;
    assign any     = |vec;

    // Prefer requests at or above the pointer, fall back to the wrapped search.
    always_comb begin
        idx = '0;
        if (|masked) idx = lowest(masked);
        else         idx = lowest(vec);
    end

endmodule

// File: rtl/address_encoder_rr.sv
// Collects row request strobes and offers them as a binary address.
// Grants rotate round-robin and leave through a valid/ready handshake.
module address_encoder_rr
    import address_encoder_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             flush,
    input  logic             ready,
    output logic [ADR_W-1:0] adr,
    output logic             valid,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    state_t           state;
    logic [ADR_W-1:0] ptr;
    logic             accept;
    logic [N_REQ-1:0] clr_mask;
    logic [N_REQ-1:0] pending_next;
    logic [N_REQ-1:0] pick_vec;
    logic [ADR_W-1:0] pick_ptr;
    logic [ADR_W-1:0] pick_idx;
    logic             pick_any;

    assign accept       = valid && ready;
    assign clr_mask     = accept ? N_REQ'(onehot(6'(adr))) : '0;
    assign pending_next = (pending & ~clr_mask) | req;
    assign busy         = valid || (|pending);

    // Next grant is searched in the registered pending set minus the one leaving.
    assign pick_vec = pending & ~clr_mask;
    assign pick_ptr = accept ? adr + ADR_W'(1) : ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ADR_W (ADR_W)
    ) u_pick (
        .vec (pick_vec),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Pending register, rr pointer and offer FSM with registered adr/valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            adr     <= '0;
            valid   <= 1'b0;
            ptr     <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            pending <= '0;
            valid   <= 1'b0;
        end else begin
            pending <= pending_next;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        adr   <= pick_idx;
                        valid <= 1'b1;
                        state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (accept) begin
                        ptr <= adr + ADR_W'(1);
                        if (pick_any) begin
                            adr <= pick_idx;
                        end else begin
                            valid <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_address_encoder_rr.sv
// Directed bench for address_encoder_rr with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_address_encoder_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       flush;
    logic       ready;
    logic [2:0] adr;
    logic       valid;
    logic [7:0] pending;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    address_encoder_rr #(
        .N_REQ (8),
        .ADR_W (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .flush   (flush),
        .ready   (ready),
        .adr     (adr),
        .valid   (valid),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        flush = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // single request
        req = 8'h20;
        tick();
        req = '0;
        chk("s_pend", 64'(pending), 64'h20);
        chk("s_valid0", 64'(valid), 64'd0);
        tick();
        chk("s_valid1", 64'(valid), 64'd1);
        chk("s_adr", 64'(adr), 64'd5);
        tick();
        chk("s_done", 64'(valid), 64'd0);
        chk("s_pend0", 64'(pending), 64'd0);
        chk("s_busy", 64'(busy), 64'd0);
        chk("s_adr_hold", 64'(adr), 64'd5);

        // round robin from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'h85;
        tick();
        req = '0;
        tick();
        chk("rr_0", 64'(adr), 64'd0);
        tick();
        chk("rr_2", 64'(adr), 64'd2);
        tick();
        chk("rr_7", 64'(adr), 64'd7);
        chk("rr_v", 64'(valid), 64'd1);
        tick();
        chk("rr_end", 64'(valid), 64'd0);
        req = 8'h81;
        tick();
        req = '0;
        tick();
        chk("rr_ptr0", 64'(adr), 64'd0);
        tick();
        chk("rr_ptr7", 64'(adr), 64'd7);
        tick();
        chk("rr_end2", 64'(valid), 64'd0);

        // backpressure
        ready = 1'b0;
        req = 8'h08;
        tick();
        req = '0;
        tick();
        chk("bp_adr", 64'(adr), 64'd3);
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 8'h40 : 8'h00;
            tick();
            chk("bp_hold_adr", 64'(adr), 64'd3);
            chk("bp_hold_v", 64'(valid), 64'd1);
        end
        req = '0;
        chk("bp_pend", 64'(pending), 64'h48);
        ready = 1'b1;
        tick();
        chk("bp_next6", 64'(adr), 64'd6);
        chk("bp_v6", 64'(valid), 64'd1);
        tick();
        chk("bp_end", 64'(valid), 64'd0);

        // wrap: grant 5 from ptr 7, leaving ptr 6
        req = 8'h20;
        tick();
        req = '0;
        tick();
        chk("wr_5", 64'(adr), 64'd5);
        tick();
        req = 8'h42;
        tick();
        req = '0;
        tick();
        chk("wr_6", 64'(adr), 64'd6);
        tick();
        chk("wr_1", 64'(adr), 64'd1);
        tick();
        chk("wr_end", 64'(valid), 64'd0);

        // same-cycle re-request, pointer at 2
        ready = 1'b0;
        req = 8'h16;
        tick();
        req = '0;
        tick();
        chk("rq_2", 64'(adr), 64'd2);
        ready = 1'b1;
        req = 8'h04;
        tick();
        req = '0;
        chk("rq_4", 64'(adr), 64'd4);
        chk("rq_pend", 64'(pending), 64'h16);
        tick();
        chk("rq_1", 64'(adr), 64'd1);
        tick();
        chk("rq_2again", 64'(adr), 64'd2);
        chk("rq_v", 64'(valid), 64'd1);
        tick();
        chk("rq_end", 64'(valid), 64'd0);
        chk("rq_pend0", 64'(pending), 64'd0);

        // flush mid-offer, pointer at 3
        ready = 1'b0;
        req = 8'hFF;
        tick();
        req = '0;
        tick();
        chk("fl_v", 64'(valid), 64'd1);
        chk("fl_pend", 64'(pending), 64'hFF);
        flush = 1'b1;
        req = 8'h01;
        tick();
        flush = 1'b0;
        req = '0;
        chk("fl_v0", 64'(valid), 64'd0);
        chk("fl_pend0", 64'(pending), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        tick();
        chk("fl_quiet", 64'(valid), 64'd0);

        // reset mid-offer
        req = 8'hFF;
        tick();
        req = '0;
        tick();
        chk("rs_adr3", 64'(adr), 64'd3);
        rst_n = 1'b0;
        tick();
        chk("rs_v0", 64'(valid), 64'd0);
        chk("rs_pend0", 64'(pending), 64'd0);
        chk("rs_adr0", 64'(adr), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rs_quiet", 64'(valid), 64'd0);
        ready = 1'b1;
        req = 8'h0A;
        tick();
        req = '0;
        tick();
        chk("rs_ptr", 64'(adr), 64'd1);
        tick();
        chk("rs_3", 64'(adr), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/address_encoder_rr.md
Name: address_encoder_rr

Overview:
- Reverse direction of the row address decoder: collects one-hot/multi-hot row request strobes and encodes them into a binary address with a valid flag.
- Output pair adr/valid connects directly to the decoder's adr/select inputs.
- Requests are latched into a pending vector, granted in round-robin order, and presented through a valid/ready handshake.
- Sits between the bitcell array's request lines and the row decoder or access sequencer.

Parameters:
- N_REQ, 8, number of request lines; power of two, 2..64.
- ADR_W, 3, address width; must equal clog2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  N_REQ  request strobes; any bit high for one or more cycles marks that index pending.
- flush  input  1  synchronous clear of all pending requests and any current offer.
- ready  input  1  consumer accepts the current adr when valid && ready.
- adr  output  ADR_W  encoded index of the granted request; registered.
- valid  output  1  adr holds a pending request; registered.
- pending  output  N_REQ  current pending vector; registered.
- busy  output  1  valid || (pending != 0); combinational from registers.

Behaviour:
- Reset (rst_n=0 at posedge): pending=0, adr=0, valid=0, rr pointer=0, state=IDLE. Reset overrides flush and req.
- Pending update each cycle: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of adr when valid && ready, else 0.
  - When req[i] and clear of i occur in the same cycle, the bit stays set, so the new request is not lost.
- flush=1 (rst_n=1): pending=0, valid=0, state=IDLE, pointer unchanged. req arriving in the same cycle is discarded.
- Round-robin pick: the first set bit of the candidate vector, searching upward from pointer with wrap at N_REQ-1 to 0.
- FSM states are IDLE and OFFER.
  - IDLE: if the registered pending != 0, pick from pending, load adr, set valid=1, go to OFFER. Otherwise stay.
  - OFFER, valid && !ready: adr and valid are held stable with no change at all, even if new requests arrive.
  - OFFER, valid && ready: pointer = (adr+1) mod N_REQ. Candidate = pending & ~onehot(adr), using registered values and excluding same-cycle req.
    - Candidate != 0: load the picked adr and stay in OFFER. This gives back-to-back grants, one per cycle.
    - Candidate == 0: valid=0, go to IDLE.
- Latency: req high at edge n gives pending at n+1 and valid/adr at n+2 (from IDLE). Sustained throughput is 1 grant/cycle while ready=1.
- Duplicate strobes on an already-pending index merge, so at most one grant is issued per index per pending period.
- adr is don't-care when valid=0 but is kept at its last value, with no toggling.
- Reset asserted mid-offer drops everything in the same edge. Nothing is granted after reset until new req.

Decomposition:
- Package address_encoder_pkg: state enum (ST_IDLE, ST_OFFER), default N_REQ/ADR_W constants, and function onehot(adr).
- Sub-module rr_pick: combinational masked priority encoder.
  - Inputs: vec[N_REQ], ptr[ADR_W].
  - Outputs: idx[ADR_W], any.
  - Implementation: double-width or mask-and-fallback scheme.
- Top-level contents: FSM, pending register, pointer, and handshake.

Test Plan:
- Single request: req=8'b0010_0000 for 1 cycle, ready=1. Expect valid=1 with adr=5 two cycles later for exactly one cycle; pending returns to 0 after acceptance.
- Round robin: req=8'b1000_0101 in one cycle, ready=1. Expect the grant sequence adr=0,2,7 on consecutive cycles, then valid=0; pointer ends at 0.
- Backpressure: req[3]=1, hold ready=0 for 5 cycles while pulsing req[6]. Expect adr=3 stable and valid=1 throughout; after ready=1, adr=3 accepted, then adr=6 on the next cycle.
- Wrap and fairness: pointer at 6 after granting adr=5, pending=8'b0100_0010. Expect adr=6 before adr=1.
- Same-cycle re-request: while adr=2 is offered, ready=1 and req[2]=1 in the same cycle. Expect pending[2] to remain 1 and adr=2 re-granted after the other pending indices in rr order.
- Flush/reset: pending=8'hFF, valid=1, assert flush for 1 cycle. Expect next-cycle valid=0 and pending=0. Repeat with rst_n=0 mid-offer and also expect adr=0.
